// File: rtl/pad_streamer.sv
// pad_streamer: streams an HxWxC map as a zero-padded (H+2)x(W+2) sequence of 8x8-bit channel vectors
module pad_streamer #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  in_channels,
  input  logic [CNT_W-1:0]  img_height,
  input  logic [CNT_W-1:0]  img_width,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic              done
);
  typedef enum logic [1:0] {IDLE, STREAM, FIN} state_t;
  state_t st, st_nx;
  logic [CNT_W-1:0] gm1, grp;
  logic [CNT_W:0] h1, w1, row, col;
  logic fin, zero_cfg, go, pad, grp_last, col_last, is_last, act, ld_ok, ld;
  assign zero_cfg = in_channels[CNT_W-1:3] == '0 || img_height == '0 || img_width == '0;
  assign go = st == IDLE && start;
  assign pad = row == '0 || row == h1 || col == '0 || col == w1;
  assign grp_last = grp == gm1;
  assign col_last = col == w1;
  assign is_last = grp_last && col_last && row == h1;
  // fin stops loading once the final vector sits in the output register
  assign act = st == STREAM && !fin;
  assign ld_ok = !m_valid || m_ready;
  assign s_ready = act && !pad && ld_ok;
  assign ld = act && ld_ok && (pad || s_valid);
  assign busy = st != IDLE;
  assign done = st == FIN;
  always_ff @(posedge clk)
    if (rst) st <= IDLE;
    else st <= st_nx;
  always_comb begin
    st_nx = st;
    if (go) st_nx = zero_cfg ? FIN : STREAM;
    else if (st == STREAM && m_valid && m_ready && m_last) st_nx = FIN;
    else if (st == FIN) st_nx = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      gm1 <= '0;
      h1 <= '0;
      w1 <= '0;
      grp <= '0;
      col <= '0;
      row <= '0;
      fin <= 1'b0;
      m_valid <= 1'b0;
      m_data <= '0;
      m_last <= 1'b0;
    end else if (go) begin
      gm1 <= {3'b0, in_channels[CNT_W-1:3]} - CNT_W'(1);
      h1 <= {1'b0, img_height} + (CNT_W+1)'(1);
      w1 <= {1'b0, img_width} + (CNT_W+1)'(1);
      fin <= 1'b0;
      row <= '0;
      // top-left pad is loaded on the start edge so it appears one cycle later
      grp <= in_channels[CNT_W-1:3] == (CNT_W-3)'(1) ? '0 : CNT_W'(1);
      col <= in_channels[CNT_W-1:3] == (CNT_W-3)'(1) ? (CNT_W+1)'(1) : '0;
      m_valid <= !zero_cfg;
      m_data <= '0;
      m_last <= 1'b0;
    end else if (ld) begin
      m_valid <= 1'b1;
      m_data <= pad ? '0 : s_data;
      m_last <= is_last;
      fin <= is_last;
      grp <= grp_last ? '0 : grp + CNT_W'(1);
      if (grp_last) col <= col_last ? '0 : col + (CNT_W+1)'(1);
      if (grp_last && col_last) row <= row + (CNT_W+1)'(1);
    end else if (m_ready) begin
      m_valid <= 1'b0;
      m_last <= 1'b0;
    end
  end
endmodule

// File: tb/tb_pad_streamer.sv
// tb_pad_streamer: scoreboard bench; expected beats queued at stimulus time, checked by a monitor on accept
module tb_pad_streamer;
  localparam int DW = 64;
  localparam int CW = 16;
  localparam logic [DW-1:0] REP = 64'h0101010101010101;
  logic clk = 0, rst = 1, start = 0, s_valid = 0, m_ready = 1;
  logic [CW-1:0] in_channels = 0, img_height = 0, img_width = 0;
  logic [DW-1:0] s_data = 0, m_data, prev_data = 0;
  logic s_ready, m_valid, m_last, busy, done;
  typedef struct packed {logic [DW-1:0] d; logic l;} beat_t;
  beat_t exp_q[$];
  beat_t b;
  logic [DW-1:0] src_q[$];
  int n_cmp = 0, n_bad = 0, cyc = 0, last_cyc = -10, rmode = 0, hold_cnt = 0;
  bit src_acc = 0, prev_stall = 0, bub_prev = 0, chk_bubble = 0;
  logic [3:0] pat = 4'b1001;

  pad_streamer dut (
    .clk(clk), .rst(rst), .start(start), .in_channels(in_channels),
    .img_height(img_height), .img_width(img_width), .s_valid(s_valid),
    .s_ready(s_ready), .s_data(s_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    #1;
    if (src_acc && src_q.size() > 0) void'(src_q.pop_front());
    m_ready = rmode != 0 ? pat[cyc % 4] : 1'b1;
    s_valid = src_q.size() > 0 && hold_cnt == 0;
    s_data = src_q.size() > 0 ? src_q[0] : '0;
  end

  always @(negedge clk) begin
    src_acc = s_valid && s_ready && !rst;
    if (!rst) begin
      if (prev_stall) begin
        check("hold_valid", 64'(m_valid), 1);
        check("hold_data", m_data, prev_data);
      end
      if (chk_bubble && hold_cnt > 0 && s_ready && bub_prev) check("bubble_valid", 64'(m_valid), 0);
      bub_prev = hold_cnt > 0 && s_ready;
      if (hold_cnt > 0 && s_ready) hold_cnt--;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) check("extra_beat", 1, 0);
        else begin
          b = exp_q.pop_front();
          check("beat_data", m_data, b.d);
          check("beat_last", 64'(m_last), 64'(b.l));
        end
        if (m_last) last_cyc = cyc;
      end
    end
    prev_stall = !rst && m_valid && !m_ready;
    prev_data = m_data;
  end

  task automatic push_exp(input int h, input int w, input int c, input int base);
    int v = base;
    int g = c / 8;
    if (h == 0 || w == 0 || g == 0) return;
    for (int r = 0; r < h + 2; r++)
      for (int x = 0; x < w + 2; x++)
        for (int k = 0; k < g; k++) begin
          logic l = r == h + 1 && x == w + 1 && k == g - 1;
          if (r == 0 || r == h + 1 || x == 0 || x == w + 1) exp_q.push_back('{d: '0, l: l});
          else begin
            exp_q.push_back('{d: REP * v, l: l});
            src_q.push_back(REP * v);
            v++;
          end
        end
  endtask

  task automatic pulse_start(input int h, input int w, input int c);
    @(posedge clk);
    #1;
    img_height = CW'(h);
    img_width = CW'(w);
    in_channels = CW'(c);
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
  endtask

  task automatic run_frame(input int h, input int w, input int c, input int base, input bit restart);
    int n;
    push_exp(h, w, c, base);
    pulse_start(h, w, c);
    if (h == 0 || w == 0 || c / 8 == 0) begin
      check("zero_done", 64'(done), 1);
      check("zero_mvalid", 64'(m_valid), 0);
      @(posedge clk);
      #1;
      check("zero_after", {62'(0), done, m_valid}, 0);
      return;
    end
    check("first_latency", {62'(0), m_valid, busy}, 3);
    if (restart) begin
      repeat (4) @(posedge clk);
      #1;
      img_height = CW'(h + 3);
      img_width = CW'(w + 2);
      start = 1;
      @(posedge clk);
      #1;
      start = 0;
    end
    for (n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (done) break;
    end
    check("done_timeout", 64'(n < 3000), 1);
    check("done_gap", 64'(cyc - last_cyc), 1);
    check("exp_drained", 64'(exp_q.size()), 0);
    check("src_drained", 64'(src_q.size()), 0);
    @(negedge clk);
    check("done_pulse", {62'(0), done, busy}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_data", m_data, 0);
    check("reset_ctl", {59'(0), m_valid, m_last, s_ready, busy, done}, 0);
    rst = 0;
    run_frame(2, 2, 8, 1, 0);
    run_frame(1, 1, 16, 10, 0);
    rmode = 1;
    run_frame(2, 3, 16, 20, 0);
    rmode = 0;
    hold_cnt = 5;
    chk_bubble = 1;
    run_frame(2, 2, 8, 40, 0);
    chk_bubble = 0;
    check("hold_consumed", 64'(hold_cnt), 0);
    run_frame(2, 2, 8, 50, 1);
    push_exp(2, 3, 8, 60);
    pulse_start(2, 3, 8);
    repeat (8) @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk);
    #1;
    check("rst_mid", {61'(0), m_valid, busy, s_ready}, 0);
    exp_q.delete();
    src_q.delete();
    rst = 0;
    run_frame(2, 3, 8, 70, 0);
    run_frame(2, 0, 8, 0, 0);
    rmode = 1;
    run_frame(1, 1, 16, 90, 0);
    rmode = 0;
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
